// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

    localparam int unsigned INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target arithmetic for pc_gen: branch/JALR targets, redirect
// priority (trap > JALR > branch) and misaligned-target detection.
module pc_target_calc
    import pc_gen_pkg::*;
#(
    parameter int unsigned               ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]  TRAP_VECTOR   = ADDRESS_WIDTH'(DEFAULT_TRAP_VECTOR)
) (
    input  logic                     trap_valid,
    input  logic                     jalr_valid,
    input  logic                     branch_taken,
    input  logic [ADDRESS_WIDTH-1:0] ex_pc,
    input  logic [ADDRESS_WIDTH-1:0] branch_imm,
    input  logic [ADDRESS_WIDTH-1:0] jalr_base,
    input  logic [ADDRESS_WIDTH-1:0] jalr_imm,
    output logic                     load,
    output logic [ADDRESS_WIDTH-1:0] load_pc,
    output logic                     misalign,
    output logic [ADDRESS_WIDTH-1:0] raw_target
);

    logic [ADDRESS_WIDTH-1:0] branch_target;
    logic [ADDRESS_WIDTH-1:0] jalr_sum;
    logic [ADDRESS_WIDTH-1:0] jalr_target;

    always_comb begin
        branch_target = ex_pc + branch_imm;
        jalr_sum      = jalr_base + jalr_imm;
        jalr_target   = {jalr_sum[ADDRESS_WIDTH-1:1], 1'b0};

        load       = trap_valid | jalr_valid | branch_taken;
        raw_target = jalr_valid ? jalr_target : branch_target;

        // A trap never has a computed target, so it can never be misaligned.
        misalign = !trap_valid && (jalr_valid || branch_taken) &&
                   (raw_target[1:0] != 2'b00);
        load_pc  = (trap_valid || misalign) ? TRAP_VECTOR : raw_target;
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: BOOT/RUN/HALT control, PC register,
// fetch handshake, redirect/misalign pulses and accepted-fetch counter.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned               ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]  RESET_VECTOR  = ADDRESS_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [ADDRESS_WIDTH-1:0]  TRAP_VECTOR   = ADDRESS_WIDTH'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned               CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     fetch_ready,
    input  logic                     branch_taken,
    input  logic [ADDRESS_WIDTH-1:0] ex_pc,
    input  logic [ADDRESS_WIDTH-1:0] branch_imm,
    input  logic                     jalr_valid,
    input  logic [ADDRESS_WIDTH-1:0] jalr_base,
    input  logic [ADDRESS_WIDTH-1:0] jalr_imm,
    input  logic                     trap_valid,
    input  logic                     halt_req,
    input  logic                     resume,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4,
    output logic                     fetch_valid,
    output logic                     redirect,
    output logic                     misalign_err,
    output logic [ADDRESS_WIDTH-1:0] err_addr,
    output logic [CNT_WIDTH-1:0]     fetch_count
);

    pc_state_t                state;
    logic                     accept;
    logic                     tgt_load;
    logic                     tgt_misalign;
    logic [ADDRESS_WIDTH-1:0] tgt_pc;
    logic [ADDRESS_WIDTH-1:0] tgt_raw;

    pc_target_calc #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .TRAP_VECTOR   (TRAP_VECTOR)
    ) u_target (
        .trap_valid   (trap_valid),
        .jalr_valid   (jalr_valid),
        .branch_taken (branch_taken),
        .ex_pc        (ex_pc),
        .branch_imm   (branch_imm),
        .jalr_base    (jalr_base),
        .jalr_imm     (jalr_imm),
        .load         (tgt_load),
        .load_pc      (tgt_pc),
        .misalign     (tgt_misalign),
        .raw_target   (tgt_raw)
    );

    always_comb begin
        pc_plus4 = pc + ADDRESS_WIDTH'(INSTR_BYTES);
        accept   = fetch_valid & fetch_ready & ~stall;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_BOOT;
            pc           <= RESET_VECTOR;
            fetch_valid  <= 1'b0;
            redirect     <= 1'b0;
            misalign_err <= 1'b0;
            err_addr     <= '0;
            fetch_count  <= '0;
        end else begin
            redirect     <= 1'b0;
            misalign_err <= 1'b0;
            // fetch_valid is only ever high in RUN, so this never counts elsewhere.
            if (accept)
                fetch_count <= fetch_count + CNT_WIDTH'(1);

            unique case (state)
                ST_BOOT: begin
                    state       <= ST_RUN;
                    fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (tgt_load) begin
                        pc       <= tgt_pc;
                        redirect <= 1'b1;
                        if (tgt_misalign) begin
                            misalign_err <= 1'b1;
                            err_addr     <= tgt_raw;
                        end
                    end else if (accept) begin
                        pc <= pc_plus4;
                    end
                    if (halt_req) begin
                        state       <= ST_HALT;
                        fetch_valid <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (trap_valid) begin
                        pc       <= TRAP_VECTOR;
                        redirect <= 1'b1;
                    end
                    if (resume && !halt_req) begin
                        state       <= ST_RUN;
                        fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_BOOT;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by random
// stimulus, all compared every cycle against a behavioural model.
module tb_pc_gen;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 4;
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic          clk = 1'b0;
    logic          rst_n, stall, fetch_ready, branch_taken, jalr_valid;
    logic          trap_valid, halt_req, resume;
    logic [AW-1:0] ex_pc, branch_imm, jalr_base, jalr_imm;
    logic [AW-1:0] pc, pc_plus4, err_addr;
    logic          fetch_valid, redirect, misalign_err;
    logic [CW-1:0] fetch_count;

    always #5 clk = ~clk;

    pc_gen #(
        .ADDRESS_WIDTH (AW),
        .RESET_VECTOR  (RV),
        .TRAP_VECTOR   (TV),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .fetch_ready  (fetch_ready),
        .branch_taken (branch_taken),
        .ex_pc        (ex_pc),
        .branch_imm   (branch_imm),
        .jalr_valid   (jalr_valid),
        .jalr_base    (jalr_base),
        .jalr_imm     (jalr_imm),
        .trap_valid   (trap_valid),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fetch_valid  (fetch_valid),
        .redirect     (redirect),
        .misalign_err (misalign_err),
        .err_addr     (err_addr),
        .fetch_count  (fetch_count)
    );

    int          m_mode;
    logic [31:0] m_pc, m_err;
    logic        m_redir, m_mis;
    int unsigned m_cnt;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour, evaluated with the inputs present at the clock edge.
    task automatic model_step();
        logic [31:0] tgt;
        bit          acc, take;
        if (!rst_n) begin
            m_mode = M_BOOT; m_pc = RV; m_err = 0;
            m_redir = 0; m_mis = 0; m_cnt = 0;
            return;
        end
        acc     = (m_mode == M_RUN) && fetch_ready && !stall;
        m_redir = 0;
        m_mis   = 0;
        if (acc) m_cnt = (m_cnt + 1) % (1 << CW);
        if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            take = 1;
            tgt  = 0;
            if (trap_valid)        tgt = TV;
            else if (jalr_valid)   tgt = (jalr_base + jalr_imm) & ~32'd1;
            else if (branch_taken) tgt = ex_pc + branch_imm;
            else                   take = 0;
            if (take) begin
                m_redir = 1;
                if (!trap_valid && (tgt % 4 != 0)) begin
                    m_mis = 1; m_err = tgt; m_pc = TV;
                end else begin
                    m_pc = tgt;
                end
            end else if (acc) begin
                m_pc = m_pc + 4;
            end
            if (halt_req) m_mode = M_HALT;
        end else begin
            if (trap_valid) begin m_pc = TV; m_redir = 1; end
            if (resume && !halt_req) m_mode = M_RUN;
        end
    endtask

    task automatic compare_all();
        check_val("pc",           pc,                    m_pc);
        check_val("pc_plus4",     pc_plus4,              m_pc + 32'd4);
        check_val("fetch_valid",  {31'b0, fetch_valid},  {31'b0, m_mode == M_RUN});
        check_val("redirect",     {31'b0, redirect},     {31'b0, m_redir});
        check_val("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
        check_val("err_addr",     err_addr,              m_err);
        check_val("fetch_count",  32'(fetch_count),      m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        rst_n = 1; stall = 0; fetch_ready = 1;
        branch_taken = 0; jalr_valid = 0; trap_valid = 0;
        halt_req = 0; resume = 0;
        ex_pc = 0; branch_imm = 0; jalr_base = 0; jalr_imm = 0;
    endtask

    initial begin
        idle_inputs();
        m_mode = M_BOOT; m_pc = RV; m_err = 0; m_redir = 0; m_mis = 0; m_cnt = 0;
        #2;

        // Reset then run
        rst_n = 0;
        tick(); tick();
        check_val("rst_pc", pc, RV);
        check_val("rst_fv", {31'b0, fetch_valid}, 32'd0);
        rst_n = 1;
        tick();
        check_val("boot_pc", pc, 32'h0);
        tick(); tick();
        check_val("run_pc8", pc, 32'h8);
        check_val("run_cnt2", 32'(fetch_count), 32'd2);

        // Backpressure then stall
        fetch_ready = 0;
        repeat (3) tick();
        fetch_ready = 1; stall = 1;
        repeat (2) tick();
        check_val("hold_pc", pc, 32'h8);
        stall = 0;
        tick();
        check_val("release_pc", pc, 32'hC);

        // Branch, then JALR winning over branch
        branch_taken = 1; ex_pc = 32'h10; branch_imm = 32'hFFFF_FFF8;
        tick();
        check_val("br_pc", pc, 32'h8);
        check_val("br_redir", {31'b0, redirect}, 32'd1);
        jalr_valid = 1; jalr_base = 32'h40; jalr_imm = 32'h5;
        tick();
        check_val("jalr_pc", pc, 32'h44);
        branch_taken = 0;

        // Misaligned JALR target
        jalr_imm = 32'h2;
        tick();
        check_val("mis_pc", pc, TV);
        check_val("mis_err", err_addr, 32'h42);
        jalr_valid = 0;
        tick();
        check_val("mis_pulse", {31'b0, misalign_err}, 32'd0);

        // Halt with same-cycle redirect, trap in HALT, resume
        branch_taken = 1; ex_pc = 32'h20; branch_imm = 0; halt_req = 1;
        tick();
        branch_taken = 0; halt_req = 0;
        repeat (2) tick();
        check_val("halt_pc", pc, 32'h20);
        trap_valid = 1;
        tick();
        check_val("halt_trap", pc, TV);
        trap_valid = 0;
        tick();
        check_val("still_halt", {31'b0, fetch_valid}, 32'd0);
        resume = 1;
        tick();
        resume = 0;
        check_val("resume_fv", {31'b0, fetch_valid}, 32'd1);
        tick();
        check_val("resume_pc", pc, 32'h104);

        // Counter wrap, then reset concurrent with a branch
        rst_n = 0; tick(); rst_n = 1; tick();
        repeat (17) tick();
        check_val("wrap_cnt", 32'(fetch_count), 32'd1);
        rst_n = 0; branch_taken = 1; ex_pc = 32'h80; branch_imm = 32'h8;
        tick();
        check_val("rst_mid_pc", pc, RV);
        check_val("rst_mid_redir", {31'b0, redirect}, 32'd0);
        idle_inputs();

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom % 200) != 0;
            stall        = ($urandom % 4) == 0;
            fetch_ready  = ($urandom % 4) != 0;
            branch_taken = ($urandom % 6) == 0;
            jalr_valid   = ($urandom % 8) == 0;
            trap_valid   = ($urandom % 20) == 0;
            halt_req     = ($urandom % 25) == 0;
            resume       = ($urandom % 5) == 0;
            ex_pc        = $urandom & 32'hFFFF_FFFC;
            branch_imm   = (($urandom % 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            jalr_base    = $urandom;
            jalr_imm     = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage; the successor to the single-mux PC register.
- Adds fetch valid/ready handshake, stall, and prioritised redirects (trap, JALR, branch).
- Detects misaligned targets, supports a halt/resume mode and counts accepted fetches.
- Drives the instruction-memory address; feeds pc_plus4 to the ALU/writeback path and a flush pulse to IF/ID.

Parameters:
ADDRESS_WIDTH, 32, width of every address/immediate port
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned target
CNT_WIDTH, 16, width of fetch_count

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  synchronous active-low reset
stall  in  1  hold sequential PC advance
fetch_ready  in  1  imem accepts current pc
branch_taken  in  1  EX-stage branch resolved taken
ex_pc  in  ADDRESS_WIDTH  PC of the EX-stage instruction
branch_imm  in  ADDRESS_WIDTH  sign-extended branch offset
jalr_valid  in  1  EX-stage JALR
jalr_base  in  ADDRESS_WIDTH  rs1 value
jalr_imm  in  ADDRESS_WIDTH  sign-extended JALR offset
trap_valid  in  1  exception/interrupt request
halt_req  in  1  enter HALT
resume  in  1  leave HALT
pc  out  ADDRESS_WIDTH  current fetch address
pc_plus4  out  ADDRESS_WIDTH  pc + 4, combinational
fetch_valid  out  1  pc is a valid fetch request
redirect  out  1  one-cycle flush pulse to IF/ID
misalign_err  out  1  one-cycle misaligned-target pulse
err_addr  out  ADDRESS_WIDTH  last offending target
fetch_count  out  CNT_WIDTH  accepted-fetch counter

Behaviour:
- Reset (rst_n=0 at posedge): state=BOOT, pc=RESET_VECTOR, fetch_valid=0, redirect=0, misalign_err=0, err_addr=0, fetch_count=0. Reset overrides every other input, including mid-redirect.
- States: BOOT, RUN, HALT. fetch_valid=1 only in RUN (registered decode of state).
- BOOT: always goes to RUN after one cycle; pc is held.
- Targets: branch = ex_pc + branch_imm; jalr = (jalr_base + jalr_imm) with bit0 cleared. All adds are modulo 2^ADDRESS_WIDTH.
- Misaligned: a selected target with bits[1:0] != 0 loads pc=TRAP_VECTOR and err_addr=target, and pulses misalign_err.
- RUN next-PC priority, evaluated each cycle:
  1. trap_valid -> TRAP_VECTOR
  2. jalr_valid -> jalr target
  3. branch_taken -> branch target
  4. fetch_valid & fetch_ready & !stall -> pc+4
  5. otherwise hold
- Redirects (1-3) ignore stall and fetch_ready.
- redirect is registered: high the cycle after pc was loaded by 1-3 (including misalign-to-trap), otherwise 0.
- fetch_count increments by 1 on each cycle with fetch_valid & fetch_ready & !stall, and wraps at 2^CNT_WIDTH. A redirect in the same cycle still counts the accepted fetch.
- RUN -> HALT on halt_req. A redirect in the same cycle is applied first.
- HALT:
  - fetch_valid=0; pc held.
  - trap_valid still loads TRAP_VECTOR and pulses redirect, staying in HALT.
  - jalr/branch are ignored.
  - resume -> RUN next cycle. halt_req and resume together -> stay in HALT.
- Latency: one cycle from any input event to the pc update. pc_plus4 tracks pc combinationally.

Decomposition:
- Package pc_gen_pkg: state enum (BOOT, RUN, HALT), INSTR_BYTES=4, default RESET_VECTOR/TRAP_VECTOR constants.
- Sub-module pc_target_calc (combinational): computes branch/JALR targets, priority select and misalign flag. pc_gen keeps the FSM, PC register, counter and pulses.

Test Plan:
- Reset then run: rst_n low 2 cycles, fetch_ready=1 -> BOOT cycle with fetch_valid=0 and pc=0; then pc=0,4,8,C with fetch_count 1,2,3.
- Backpressure/stall: at pc=8, fetch_ready=0 for 3 cycles, then stall=1 for 2 cycles -> pc stays 8 and fetch_count unchanged; release -> pc=C.
- Branch and priority: ex_pc=0x10, branch_imm=0xFFFF_FFF8 -> pc=0x8 and redirect pulse next cycle. Repeat with jalr_base=0x40, jalr_imm=0x5 in the same cycle -> pc=0x44 (JALR wins, bit0 cleared).
- Misalign: jalr_base=0x40, jalr_imm=0x2 -> pc=0x100, misalign_err=1 for one cycle, err_addr=0x42, redirect=1.
- Halt: halt_req at pc=0x20 -> fetch_valid=0, pc holds 0x20. trap_valid in HALT -> pc=0x100, still HALT. resume -> fetch_valid=1, pc=0x100 then 0x104.
- Reset mid-operation and wrap: CNT_WIDTH=4, 17 accepted fetches -> fetch_count=1. Then rst_n=0 concurrent with branch_taken -> pc=RESET_VECTOR, all outputs at reset values.
